// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
//
// Purpose:
//   APB4 completer that holds a bank of NUM_REGS word registers. It supports
//   a fixed number of wait states, PSTRB byte-lane writes, read-only registers
//   whose read value comes from hardware (ro_data), and deterministic PSLVERR
//   decoding. All RW register contents are exported on reg_out.
//
// Optional feature macro:
//   APB_SLV_PROT_EN - adds input PPROT[2:0]. Writes with PPROT[0]=0
//                     (unprivileged) are rejected with PSLVERR and do not
//                     modify any register. Reads are unaffected.
//
// Ports:
//   PCLK     in   clock
//   PRESET   in   asynchronous reset, active-high
//   PSEL     in   APB select
//   PENABLE  in   APB access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address, word index = PADDR[ADDR_WIDTH-1:2]
//   PWDATA   in   write data
//   PSTRB    in   write byte strobes
//   PPROT    in   protection attributes (APB_SLV_PROT_EN only)
//   PRDATA   out  read data, valid when PREADY=1 on a read
//   PREADY   out  transfer completion
//   PSLVERR  out  error response, valid when PREADY=1
//   ro_data  in   read value of RO registers, slice i -> register i
//   reg_out  out  contents of all RW registers, RO slices drive 0
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
   parameter int                     ADDR_WIDTH  = 10,
   parameter int                     DATA_WIDTH  = 32,
   parameter int                     NUM_REGS    = 8,
   parameter int                     WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]    RO_MASK     = 8'h01
) (
   input  logic                           PCLK,
   input  logic                           PRESET,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   input  logic [DATA_WIDTH/8-1:0]        PSTRB,
`ifdef APB_SLV_PROT_EN
   input  logic [2:0]                     PPROT,
`endif
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PREADY,
   output logic                           PSLVERR,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int NB    = DATA_WIDTH / 8;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

   logic [IDX_W-1:0]      idx;
   logic [NUM_REGS-1:0]   sel;
   logic [DATA_WIDTH-1:0] rd_word [NUM_REGS];
   logic [DATA_WIDTH-1:0] rd_sel;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  err_addr;
   logic                  err_ro;
   logic                  err_prot;
   logic                  err;
   logic                  commit_wr;

   assign idx = PADDR[ADDR_WIDTH-1:2];

   // -----------------------------------------------------------------------
   // Register bank. RO slots have no storage: reads return ro_data and the
   // exported slice is tied to zero.
   // -----------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         assign sel[gi] = (idx == IDX_W'(gi));

         if (RO_MASK[gi]) begin : g_ro
            assign rd_word[gi] = ro_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
         end else begin : g_rw
            logic [DATA_WIDTH-1:0] word_q, word_d;
            logic                  unused_ro;

            // ro_data is meaningless for a writable slot
            assign unused_ro = ^ro_data[gi*DATA_WIDTH +: DATA_WIDTH];

            always_comb begin
               word_d = word_q;
               if (commit_wr && sel[gi]) begin
                  for (int b = 0; b < NB; b++) begin
                     if (PSTRB[b]) begin
                        word_d[b*8 +: 8] = PWDATA[b*8 +: 8];
                     end
                  end
               end
            end

            always_ff @(posedge PCLK or posedge PRESET) begin
               if (PRESET) begin
                  word_q <= '0;
               end else begin
                  word_q <= word_d;
               end
            end

            assign rd_word[gi] = word_q;
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
         end
      end
   endgenerate

   // Read mux: sel is one-hot or all-zero, so an OR-reduction is sufficient
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel[i]) begin
            rd_sel = rd_sel | rd_word[i];
         end
      end
   end

   // -----------------------------------------------------------------------
   // Error decode. An index beyond NUM_REGS selects no register, so "no
   // select line active" doubles as the out-of-range check.
   // -----------------------------------------------------------------------
`ifdef APB_SLV_PROT_EN
   logic unused_pprot;
   assign unused_pprot = ^PPROT[2:1];
   assign err_prot     = PWRITE & ~PPROT[0];
`else
   assign err_prot     = 1'b0;
`endif

   assign err_addr  = ~(|sel) | (|PADDR[1:0]);
   assign err_ro    = PWRITE & (|(sel & RO_MASK));
   assign err       = err_addr | err_ro | err_prot;
   assign resp_data = (PWRITE || err) ? '0 : rd_sel;

   // -----------------------------------------------------------------------
   // Transfer FSM
   // -----------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;
      commit_wr = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d = S_ACCESS;
               cnt_d   = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  pready_d  = 1'b1;
                  pslverr_d = err;
                  prdata_d  = resp_data;
               end
            end
         end

         S_ACCESS: begin
            if (!PSEL) begin
               // master dropped the transfer: discard it without writing
               state_d   = S_IDLE;
               cnt_d     = '0;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end else if (!pready_q) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  pready_d  = 1'b1;
                  pslverr_d = err;
                  prdata_d  = resp_data;
               end
            end else if (PENABLE) begin
               // completion edge: error status re-evaluated on the still
               // stable address/direction so errored writes never commit
               commit_wr = PWRITE & ~err;
               state_d   = S_IDLE;
               cnt_d     = '0;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;
   assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_slave
//
// Directed bench for apb_regfile_slave. Two instances share the APB bus
// signals but have separate PSEL lines: dut0 has no wait states, dut3 has
// three. Reset is shared.
// ---------------------------------------------------------------------------
module tb_apb_regfile_slave;

   logic         pclk;
   logic         preset;
   logic         psel0;
   logic         psel3;
   logic         penable;
   logic         pwrite;
   logic [9:0]   paddr;
   logic [31:0]  pwdata;
   logic [3:0]   pstrb;

   logic [31:0]  prdata0, prdata3;
   logic         pready0, pready3;
   logic         pslverr0, pslverr3;
   logic [255:0] ro_data0, ro_data3;
   logic [255:0] reg_out0, reg_out3;

   int vectors;
   int miscompares;

   apb_regfile_slave #(
      .WAIT_STATES (0)
   ) dut0 (
      .PCLK    (pclk),
      .PRESET  (preset),
      .PSEL    (psel0),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PSTRB   (pstrb),
      .PRDATA  (prdata0),
      .PREADY  (pready0),
      .PSLVERR (pslverr0),
      .ro_data (ro_data0),
      .reg_out (reg_out0)
   );

   apb_regfile_slave #(
      .WAIT_STATES (3)
   ) dut3 (
      .PCLK    (pclk),
      .PRESET  (preset),
      .PSEL    (psel3),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PSTRB   (pstrb),
      .PRDATA  (prdata3),
      .PREADY  (pready3),
      .PSLVERR (pslverr3),
      .ro_data (ro_data3),
      .reg_out (reg_out3)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // One APB transfer. Inputs change on negedges; the transfer ends with
   // PREADY seen high, and the following posedge is the completion edge.
   // waits = access cycles with PREADY low.
   task automatic xfer(input int which, input logic wr, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output logic err, output int waits);
      logic rdy;
      @(negedge pclk);
      psel0   = (which == 0);
      psel3   = (which != 0);
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wd;
      pstrb   = st;
      @(negedge pclk);
      penable = 1'b1;
      waits   = 0;
      rdy     = (which == 0) ? pready0 : pready3;
      while (!rdy && waits < 20) begin
         @(negedge pclk);
         waits++;
         rdy = (which == 0) ? pready0 : pready3;
      end
      vectors++;
      if (!rdy) begin
         miscompares++;
         $display("FAIL xfer_timeout dut%0d addr=%h: PREADY=0 after %0d cycles, required 1",
                  which, addr, waits);
      end
      rd  = (which == 0) ? prdata0 : prdata3;
      err = (which == 0) ? pslverr0 : pslverr3;
      $display("xfer dut%0d %s addr=%h wdata=%h strb=%h -> rdata=%h slverr=%0d waits=%0d",
               which, wr ? "WR" : "RD", addr, wd, st, rd, err, waits);
   endtask

   task automatic bus_idle();
      @(negedge pclk);
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge pclk);
      vectors++;
      if ({pready0, pslverr0, prdata0} !== 34'h0) begin
         miscompares++;
         $display("FAIL reset_outputs0 got rdy=%b err=%b rd=%h required 0/0/0", pready0, pslverr0, prdata0);
      end
      vectors++;
      if ({pready3, pslverr3, prdata3} !== 34'h0) begin
         miscompares++;
         $display("FAIL reset_outputs3 got rdy=%b err=%b rd=%h required 0/0/0", pready3, pslverr3, prdata3);
      end
      vectors++;
      if (reg_out0 !== 256'h0 || reg_out3 !== 256'h0) begin
         miscompares++;
         $display("FAIL reset_reg_out got %h / %h required 0", reg_out0, reg_out3);
      end
      preset = 1'b0;
      bus_idle();
      vectors++;
      if (pready0 !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_pready got %b required 0", pready0);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd;
      logic        err;
      int          w;
      xfer(0, 1'b1, 10'h004, 32'hDEADBEEF, 4'hF, rd, err, w);
      vectors++;
      if (w !== 0 || err !== 1'b0 || rd !== 32'h0) begin
         miscompares++;
         $display("FAIL wr_resp got waits=%0d err=%b rd=%h required 0/0/00000000", w, err, rd);
      end
      xfer(0, 1'b0, 10'h004, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (w !== 0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL rd_resp got waits=%0d err=%b required 0/0", w, err);
      end
      vectors++;
      if (rd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL rd_data got %h required DEADBEEF", rd);
      end
      bus_idle();
      vectors++;
      if (reg_out0[63:32] !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL reg_out1 got %h required DEADBEEF", reg_out0[63:32]);
      end
      vectors++;
      if (pready0 !== 1'b0) begin
         miscompares++;
         $display("FAIL pready_clear got %b required 0", pready0);
      end
   endtask

   task automatic test_strobes();
      logic [31:0] rd;
      logic        err;
      int          w;
      xfer(0, 1'b1, 10'h004, 32'h11223344, 4'b0101, rd, err, w);
      xfer(0, 1'b0, 10'h004, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (rd !== 32'hDE22BE44) begin
         miscompares++;
         $display("FAIL strb_partial got %h required DE22BE44", rd);
      end
      xfer(0, 1'b1, 10'h004, 32'hFFFFFFFF, 4'h0, rd, err, w);
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL strb_zero_err got %b required 0", err);
      end
      xfer(0, 1'b0, 10'h004, 32'h0, 4'hF, rd, err, w);
      vectors++;
      if (rd !== 32'hDE22BE44) begin
         miscompares++;
         $display("FAIL strb_zero_data got %h required DE22BE44", rd);
      end
      bus_idle();
   endtask

   task automatic test_read_only();
      logic [31:0] rd;
      logic        err;
      int          w;
      ro_data0[31:0]  = 32'h0000A5A5;
      ro_data0[63:32] = 32'h55555555;
      xfer(0, 1'b0, 10'h000, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (rd !== 32'h0000A5A5 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL ro_read got %h err=%b required 0000A5A5 err=0", rd, err);
      end
      xfer(0, 1'b1, 10'h000, 32'hFFFFFFFF, 4'hF, rd, err, w);
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL ro_write_err got %b required 1", err);
      end
      xfer(0, 1'b0, 10'h000, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (rd !== 32'h0000A5A5) begin
         miscompares++;
         $display("FAIL ro_reread got %h required 0000A5A5", rd);
      end
      xfer(0, 1'b0, 10'h004, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (rd !== 32'hDE22BE44) begin
         miscompares++;
         $display("FAIL rw_ignores_ro_data got %h required DE22BE44", rd);
      end
      bus_idle();
      vectors++;
      if (reg_out0[31:0] !== 32'h0) begin
         miscompares++;
         $display("FAIL ro_reg_out got %h required 0", reg_out0[31:0]);
      end
   endtask

   task automatic test_addr_errors();
      logic [31:0] rd;
      logic        err;
      int          w;
      xfer(0, 1'b0, 10'h020, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (err !== 1'b1 || rd !== 32'h0) begin
         miscompares++;
         $display("FAIL oob_read got err=%b rd=%h required 1/00000000", err, rd);
      end
      xfer(0, 1'b1, 10'h020, 32'h12345678, 4'hF, rd, err, w);
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL oob_write got err=%b required 1", err);
      end
      xfer(0, 1'b1, 10'h006, 32'h12345678, 4'hF, rd, err, w);
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL misalign_write got err=%b required 1", err);
      end
      xfer(0, 1'b0, 10'h006, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (err !== 1'b1 || rd !== 32'h0) begin
         miscompares++;
         $display("FAIL misalign_read got err=%b rd=%h required 1/00000000", err, rd);
      end
      bus_idle();
      vectors++;
      if (reg_out0 !== {192'h0, 32'hDE22BE44, 32'h0}) begin
         miscompares++;
         $display("FAIL err_no_change got %h required only reg1=DE22BE44", reg_out0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        err;
      int          w;
      xfer(3, 1'b1, 10'h008, 32'hCAFEF00D, 4'hF, rd, err, w);
      vectors++;
      if (w !== 3 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL ws_write got waits=%0d err=%b required 3/0", w, err);
      end
      xfer(3, 1'b0, 10'h008, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (w !== 3 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL ws_read got waits=%0d err=%b required 3/0", w, err);
      end
      vectors++;
      if (rd !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL ws_data got %h required CAFEF00D", rd);
      end
      bus_idle();
      vectors++;
      if (reg_out3[95:64] !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL ws_reg_out got %h required CAFEF00D", reg_out3[95:64]);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] rd;
      logic        err;
      int          w;
      @(negedge pclk);
      psel3   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 10'h008;
      pwdata  = 32'h0F0F0F0F;
      pstrb   = 4'hF;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      vectors++;
      if (pready3 !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_wait_state got PREADY=%b required 0", pready3);
      end
      // assert between edges so only an asynchronous clear can take effect
      #2 preset = 1'b1;
      #1;
      vectors++;
      if ({pready3, pslverr3, prdata3} !== 34'h0) begin
         miscompares++;
         $display("FAIL rst_outputs got rdy=%b err=%b rd=%h required 0/0/0", pready3, pslverr3, prdata3);
      end
      vectors++;
      if (reg_out3[95:64] !== 32'h0 || reg_out0[63:32] !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_regs got %h / %h required 0", reg_out3[95:64], reg_out0[63:32]);
      end
      @(negedge pclk);
      psel3   = 1'b0;
      penable = 1'b0;
      preset  = 1'b0;
      xfer(3, 1'b1, 10'h00C, 32'h0BADC0DE, 4'hF, rd, err, w);
      xfer(3, 1'b0, 10'h00C, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (rd !== 32'h0BADC0DE || err !== 1'b0 || w !== 3) begin
         miscompares++;
         $display("FAIL post_rst_xfer got rd=%h err=%b waits=%0d required 0BADC0DE/0/3", rd, err, w);
      end
      xfer(3, 1'b0, 10'h008, 32'h0, 4'h0, rd, err, w);
      vectors++;
      if (rd !== 32'h0) begin
         miscompares++;
         $display("FAIL post_rst_target got %h required 0", rd);
      end
      bus_idle();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      preset      = 1'b1;
      psel0       = 1'b0;
      psel3       = 1'b0;
      penable     = 1'b0;
      pwrite      = 1'b0;
      paddr       = '0;
      pwdata      = '0;
      pstrb       = '0;
      ro_data0    = '0;
      ro_data3    = '0;

      test_reset();
      test_write_read();
      test_strobes();
      test_read_only();
      test_addr_errors();
      test_back_to_back();
      test_async_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
